// File: rtl/wb_regfile.sv
// wb_regfile: write-back register file with 32 GPRs and the HI/LO pair.
// Reads are combinational with same-cycle write-to-read bypass; writes commit on one clk edge.
// No backpressure: the MEM/WB register inserts bubbles itself, so every enabled edge writes.
//
// Ports:
//   clk, rst                 pipeline clock; asynchronous active-high reset clearing all storage
//   wb_we/wb_waddr/wb_result GPR write from write-back (writes to r0 are dropped)
//   wb_whilo/wb_hi/wb_lo     HI/LO write, both halves in the same edge
//   re1/raddr1/rdata1        read port 1 (combinational, bypassed)
//   re2/raddr2/rdata2        read port 2 (combinational, bypassed)
//   hi_o/lo_o                current HI/LO, bypassed
//   retire_cnt               count of edges with any write enable (only when
//                            WB_RETIRE_COUNT_EN is defined)
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [31:0]       retire_cnt
`endif
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] gpr [NREG];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // Entry 0 is cleared on reset and never written, so it never holds X
    // even though reads of r0 are forced to zero below anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_we && (wb_waddr != '0)) begin
            gpr[wb_waddr] <= wb_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    // Priority order: reset, r0, bypass from the in-flight write, stored
    // value, disabled port. r0 is checked before bypass so a discarded
    // write to r0 is never forwarded.
    always_comb begin
        rdata1 = '0;
        if (rst) begin
            rdata1 = '0;
        end else if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (re1 && wb_we && (wb_waddr == raddr1)) begin
            rdata1 = wb_result;
        end else if (re1) begin
            rdata1 = gpr[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst) begin
            rdata2 = '0;
        end else if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (re2 && wb_we && (wb_waddr == raddr2)) begin
            rdata2 = wb_result;
        end else if (re2) begin
            rdata2 = gpr[raddr2];
        end
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (!rst) begin
            hi_o = wb_whilo ? wb_hi : hi_q;
            lo_o = wb_whilo ? wb_lo : lo_q;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    // A write to r0 still retires an instruction, so it counts even though
    // it changes no state. Wraps naturally at 2**32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (wb_we || wb_whilo) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_result;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_cnt;
`endif

    // Reference model: architectural state as plain arrays.
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int unsigned m_retired;

    int n_pass;
    int n_total;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_result(wb_result),
        .wb_whilo (wb_whilo),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read-port value straight from the read rules.
    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (rst) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (re && wb_we && wb_waddr == a) return wb_result;
        if (re) return m_gpr[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_hi();
        if (rst) return 32'h0;
        return wb_whilo ? wb_hi : m_hi;
    endfunction

    function automatic logic [31:0] exp_lo();
        if (rst) return 32'h0;
        return wb_whilo ? wb_lo : m_lo;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        m_retired = 0;
    endtask

    // Advance one rising edge and apply the architectural effect of the
    // inputs present at that edge; returns 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (wb_we && wb_waddr != 5'd0) m_gpr[wb_waddr] = wb_result;
            if (wb_whilo) begin
                m_hi = wb_hi;
                m_lo = wb_lo;
            end
            if (wb_we || wb_whilo) m_retired++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_waddr = 0; wb_result = 0;
        wb_whilo = 0; wb_hi = 0; wb_lo = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        model_clear();
        #3;
        re1 = 1; raddr1 = 5'd4; re2 = 1; raddr2 = 5'd31;
        #1;
        n_total++;
        if (rdata1 !== 32'h0) $display("FAIL reset_rdata1: got %h expected %h", rdata1, 32'h0);
        else n_pass++;
        n_total++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0)
            $display("FAIL reset_hilo: got %h/%h expected 0/0", hi_o, lo_o);
        else n_pass++;
        tick();
        rst = 0;
        #1;
        // Never-written registers must read a clean 0, not X.
        for (int a = 1; a < 32; a++) begin
            raddr1 = a[4:0]; raddr2 = 5'(31 - a + 1);
            #1;
            n_total++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
                $display("FAIL reset_clean_r%0d: got %h/%h expected 0/0", a, rdata1, rdata2);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        wb_we = 1; wb_waddr = 5'd3; wb_result = 32'hDEADBEEF;
        tick();
        wb_we = 0; re1 = 1; raddr1 = 5'd3;
        #1;
        n_total++;
        if (rdata1 !== 32'hDEADBEEF) $display("FAIL write_read_r3: got %h expected %h", rdata1, 32'hDEADBEEF);
        else n_pass++;
        re1 = 0;
        #1;
        n_total++;
        if (rdata1 !== 32'h0) $display("FAIL write_read_disabled: got %h expected %h", rdata1, 32'h0);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_bypass();
        wb_we = 1; wb_waddr = 5'd7; wb_result = 32'hCAFEF00D;
        re1 = 1; raddr1 = 5'd7; re2 = 1; raddr2 = 5'd7;
        #1;
        n_total++;
        if (rdata1 !== 32'hCAFEF00D || rdata2 !== 32'hCAFEF00D)
            $display("FAIL bypass_same_cycle: got %h/%h expected %h", rdata1, rdata2, 32'hCAFEF00D);
        else n_pass++;
        tick();
        wb_we = 0;
        #1;
        n_total++;
        if (rdata1 !== 32'hCAFEF00D || rdata2 !== 32'hCAFEF00D)
            $display("FAIL bypass_after_edge: got %h/%h expected %h", rdata1, rdata2, 32'hCAFEF00D);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_r0();
        wb_we = 1; wb_waddr = 5'd0; wb_result = 32'hFFFFFFFF;
        re1 = 1; raddr1 = 5'd0; re2 = 1; raddr2 = 5'd0;
        #1;
        n_total++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
            $display("FAIL r0_no_bypass: got %h/%h expected 0/0", rdata1, rdata2);
        else n_pass++;
        tick();
        wb_we = 0;
        #1;
        n_total++;
        if (rdata1 !== 32'h0) $display("FAIL r0_after_write: got %h expected %h", rdata1, 32'h0);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_hilo();
        wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2;
        wb_we = 1; wb_waddr = 5'd9; wb_result = 32'h0BAD_F00D;
        #1;
        n_total++;
        if (hi_o !== 32'h1 || lo_o !== 32'h2)
            $display("FAIL hilo_same_cycle: got %h/%h expected 1/2", hi_o, lo_o);
        else n_pass++;
        tick();
        idle_inputs();
        wb_hi = 32'hAAAA_AAAA; wb_lo = 32'h5555_5555;
        re2 = 1; raddr2 = 5'd9;
        #1;
        n_total++;
        if (hi_o !== 32'h1 || lo_o !== 32'h2)
            $display("FAIL hilo_hold: got %h/%h expected 1/2", hi_o, lo_o);
        else n_pass++;
        n_total++;
        if (rdata2 !== 32'h0BAD_F00D) $display("FAIL hilo_with_gpr_r9: got %h expected %h", rdata2, 32'h0BAD_F00D);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_async_reset();
        wb_we = 1; wb_waddr = 5'd5; wb_result = 32'h12345678;
        wb_whilo = 1; wb_hi = 32'h11; wb_lo = 32'h22;
        tick();
        // Another write to r5 is in flight when reset hits mid-cycle.
        wb_result = 32'h87654321; wb_whilo = 0;
        @(negedge clk);
        #2;
        rst = 1;
        re1 = 1; raddr1 = 5'd5;
        #1;
        n_total++;
        if (rdata1 !== 32'h0) $display("FAIL async_rst_rdata1: got %h expected %h", rdata1, 32'h0);
        else n_pass++;
        n_total++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0)
            $display("FAIL async_rst_hilo: got %h/%h expected 0/0", hi_o, lo_o);
        else n_pass++;
        model_clear();
        // Keep reset high across an edge with a write pending: it must not commit.
        wb_waddr = 5'd6; wb_whilo = 1;
        tick();
        rst = 0;
        idle_inputs();
        re1 = 1; raddr1 = 5'd5; re2 = 1; raddr2 = 5'd6;
        #1;
        n_total++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
            $display("FAIL async_rst_aborted: got %h/%h expected 0/0", rdata1, rdata2);
        else n_pass++;
        n_total++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0)
            $display("FAIL async_rst_hilo_aborted: got %h/%h expected 0/0", hi_o, lo_o);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            wb_we     = ($urandom_range(0, 99) < 60);
            wb_waddr  = 5'($urandom_range(0, 31));
            wb_result = $urandom;
            wb_whilo  = ($urandom_range(0, 99) < 30);
            wb_hi     = $urandom;
            wb_lo     = $urandom;
            re1       = ($urandom_range(0, 99) < 85);
            re2       = ($urandom_range(0, 99) < 85);
            // Aim reads at the write address often enough to exercise bypass.
            raddr1    = ($urandom_range(0, 3) == 0) ? wb_waddr : 5'($urandom_range(0, 31));
            raddr2    = ($urandom_range(0, 3) == 0) ? wb_waddr : 5'($urandom_range(0, 31));
            #1;
            n_total++;
            if (rdata1 !== exp_rd(re1, raddr1) || rdata2 !== exp_rd(re2, raddr2)
                || hi_o !== exp_hi() || lo_o !== exp_lo()) begin
                if (errs < 10)
                    $display("FAIL random_%0d: got %h %h %h %h expected %h %h %h %h", i,
                             rdata1, rdata2, hi_o, lo_o,
                             exp_rd(re1, raddr1), exp_rd(re2, raddr2), exp_hi(), exp_lo());
                errs++;
            end else n_pass++;
            tick();
        end
        idle_inputs();
        // Final sweep of the whole register file against the model.
        for (int a = 0; a < 32; a++) begin
            re1 = 1; raddr1 = a[4:0];
            #1;
            n_total++;
            if (rdata1 !== exp_rd(1'b1, a[4:0]))
                $display("FAIL sweep_r%0d: got %h expected %h", a, rdata1, exp_rd(1'b1, a[4:0]));
            else n_pass++;
        end
        idle_inputs();
    endtask

`ifdef WB_RETIRE_COUNT_EN
    task automatic test_retire_count();
        rst = 1;
        model_clear();
        #1;
        n_total++;
        if (retire_cnt !== 32'h0) $display("FAIL retire_reset: got %0d expected 0", retire_cnt);
        else n_pass++;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            wb_we = 1; wb_waddr = 5'(i); wb_result = $urandom;
            tick();
        end
        idle_inputs();
        wb_whilo = 1;
        tick();
        idle_inputs();
        tick();
        n_total++;
        if (retire_cnt !== m_retired) $display("FAIL retire_count: got %0d expected %0d", retire_cnt, m_retired);
        else n_pass++;
        rst = 1;
        #1;
        n_total++;
        if (retire_cnt !== 32'h0) $display("FAIL retire_async_clear: got %0d expected 0", retire_cnt);
        else n_pass++;
        rst = 0;
        model_clear();
    endtask
`endif

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_hilo();
        test_async_reset();
        test_random();
`ifdef WB_RETIRE_COUNT_EN
        test_retire_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
